// File: rtl/bus_sniffer_pkg.sv
// -----------------------------------------------------------------------------
// bus_sniffer_pkg
// Shared definitions for the bus sniffer: register byte offsets, CFG field
// positions, the reset-request FSM state type and address helpers.
//
// Register map (byte offsets, decoded from address bits [7:2]):
//   0x00        CTRL       bit c = channel c enable
//   0x04        STATUS     bit c = sticky hit, write 1 to clear
//   0x08 + 8*c  PATTERN c  byte 0 = oldest byte of the pattern
//   0x0C + 8*c  CFG c      [2:0] LEN, [8] MODE (0 = IRQ, 1 = reset request)
// -----------------------------------------------------------------------------
package bus_sniffer_pkg;

    localparam logic [7:0] ADDR_CTRL           = 8'h00;
    localparam logic [7:0] ADDR_STATUS         = 8'h04;
    localparam logic [7:0] ADDR_PATTERN_BASE   = 8'h08;
    localparam logic [7:0] ADDR_CFG_BASE       = 8'h0C;
    localparam logic [7:0] ADDR_CHANNEL_STRIDE = 8'h08;

    localparam logic [5:0] WORD_CTRL   = ADDR_CTRL[7:2];
    localparam logic [5:0] WORD_STATUS = ADDR_STATUS[7:2];

    localparam int CFG_LEN_LSB  = 0;
    localparam int CFG_LEN_W    = 3;
    localparam int CFG_MODE_BIT = 8;

    typedef enum logic [0:0] {
        RST_IDLE  = 1'b0,
        RST_PULSE = 1'b1
    } rst_state_e;

    // Word index (address bits [7:2]) of PATTERN register for channel ch.
    function automatic logic [5:0] pattern_word(input int ch);
        return 6'((int'(ADDR_PATTERN_BASE) + ch * int'(ADDR_CHANNEL_STRIDE)) >> 2);
    endfunction

    // Word index (address bits [7:2]) of CFG register for channel ch.
    function automatic logic [5:0] cfg_word(input int ch);
        return 6'((int'(ADDR_CFG_BASE) + ch * int'(ADDR_CHANNEL_STRIDE)) >> 2);
    endfunction

endpackage

// File: rtl/sniffer_match.sv
// -----------------------------------------------------------------------------
// sniffer_match
// Combinational length-LEN comparator for one channel. The youngest LEN bytes
// of the history window are compared against PATTERN bytes [LEN-1:0], where
// pattern byte 0 pairs with the oldest of those LEN bytes.
//
// Ports:
//   window   in  8*MAX_LEN  history incl. the byte being strobed; byte 0 = youngest
//   pattern  in  32         PATTERN register
//   len      in  3          CFG LEN (0 never matches, >MAX_LEN clamps)
//   avail    in  3          number of valid bytes in window (saturates at MAX_LEN)
//   enable   in  1          CTRL enable bit for this channel
//   hit      out 1          pattern present in window
// -----------------------------------------------------------------------------
module sniffer_match
    import bus_sniffer_pkg::*;
#(
    parameter int MAX_LEN = 4
) (
    input  logic [8*MAX_LEN-1:0] window,
    input  logic [31:0]          pattern,
    input  logic [CFG_LEN_W-1:0] len,
    input  logic [2:0]           avail,
    input  logic                 enable,
    output logic                 hit
);

    int eff_len;

    always_comb begin
        eff_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        hit     = enable && (eff_len != 0) && (int'(avail) >= eff_len);
        for (int i = 0; i < MAX_LEN; i++) begin
            // Pattern byte i sits (eff_len-1-i) bytes back from the youngest.
            if (i < eff_len) begin
                if (pattern[8*i +: 8] != window[8*(eff_len-1-i) +: 8]) begin
                    hit = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bus_sniffer.sv
// -----------------------------------------------------------------------------
// bus_sniffer
// Watches a stream of sniffed bytes and flags up to CHANNELS programmable byte
// patterns. Each hit pulses match_out, sets a sticky STATUS bit, and either
// raises irq_out (MODE 0) or launches a PULSE_CYCLES-wide reset request
// (MODE 1). Configuration is through a simple memory-mapped register bus.
//
// Build option: define BUS_SNIFFER_RESET_EN to include CFG MODE and the reset
// request FSM. Without it CFG[8] reads 0, writes to it are dropped, every
// channel behaves as IRQ mode and reset_req_out is tied low.
//
// Ports:
//   clk, reset_n      clock; asynchronous active-low reset
//   snoop_valid_in    one-cycle strobe for snoop_data_in
//   snoop_data_in     sniffed byte
//   address_in        bus address, bits [7:2] select a register
//   sel_in            peripheral select
//   read_in           read qualifier (writes happen when sel_in & !read_in)
//   write_mask_in     byte lane enables for writes
//   write_value_in    write data
//   read_value_out    read data (0 when unselected or unmapped)
//   ready_out         equals sel_in
//   match_out         per-channel match pulse, one clock after the strobe
//   irq_out           registered OR of enabled sticky hits in IRQ mode
//   reset_req_out     system reset request pulse
//
// Bus handshake: a transfer completes in the cycle sel_in is high; ready_out
// follows sel_in combinationally so there are never wait states. Read data is
// combinational; write data is captured on the rising edge.
// -----------------------------------------------------------------------------
module bus_sniffer
    import bus_sniffer_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int MAX_LEN      = 4,
    parameter int PULSE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                snoop_valid_in,
    input  logic [7:0]          snoop_data_in,
    input  logic [31:0]         address_in,
    input  logic                sel_in,
    input  logic                read_in,
    output logic [31:0]         read_value_out,
    input  logic [3:0]          write_mask_in,
    input  logic [31:0]         write_value_in,
    output logic                ready_out,
    output logic [CHANNELS-1:0] match_out,
    output logic                irq_out,
    output logic                reset_req_out
);

    logic [8*MAX_LEN-1:0]  hist_q;
    logic [8*MAX_LEN-1:0]  window;
    logic [2:0]            count_q;
    logic [2:0]            avail;

    logic [CHANNELS-1:0]   ctrl_q,   ctrl_d;
    logic [CHANNELS-1:0]   status_q, status_d;
    logic [CHANNELS-1:0]   mode_q,   mode_d;
    logic [31:0]           pattern_q [CHANNELS];
    logic [31:0]           pattern_d [CHANNELS];
    logic [CFG_LEN_W-1:0]  len_q     [CHANNELS];
    logic [CFG_LEN_W-1:0]  len_d     [CHANNELS];

    logic [CHANNELS-1:0]   hit;
    logic [CHANNELS-1:0]   match_d;
    logic                  irq_d;

    logic [5:0]            word;
    logic                  wr_en;
    logic                  unused_addr_bits;

    assign word             = address_in[7:2];
    assign wr_en            = sel_in & ~read_in;
    assign ready_out        = sel_in;
    assign unused_addr_bits = ^{address_in[31:8], address_in[1:0]};

    // Window = history shifted by the byte currently on the snoop bus, so a
    // match is registered on the same edge that captures the completing byte.
    generate
        if (MAX_LEN == 1) begin : g_win_one
            assign window = snoop_data_in;
        end else begin : g_win_many
            assign window = {hist_q[8*MAX_LEN-9:0], snoop_data_in};
        end
    endgenerate

    assign avail = (count_q == 3'(MAX_LEN)) ? count_q : count_q + 3'd1;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            sniffer_match #(
                .MAX_LEN (MAX_LEN)
            ) u_match (
                .window  (window),
                .pattern (pattern_q[c]),
                .len     (len_q[c]),
                .avail   (avail),
                .enable  (ctrl_q[c]),
                .hit     (hit[c])
            );
        end
    endgenerate

    assign match_d = snoop_valid_in ? hit : '0;

    // Register next-state: lane-masked writes, then W1C, then match sets
    // STATUS last so a coincident set beats the clear.
    always_comb begin
        ctrl_d   = ctrl_q;
        status_d = status_q;
        mode_d   = mode_q;
        for (int c = 0; c < CHANNELS; c++) begin
            pattern_d[c] = pattern_q[c];
            len_d[c]     = len_q[c];
        end
        if (wr_en) begin
            if (word == WORD_CTRL && write_mask_in[0]) begin
                ctrl_d = write_value_in[CHANNELS-1:0];
            end
            if (word == WORD_STATUS && write_mask_in[0]) begin
                status_d = status_q & ~write_value_in[CHANNELS-1:0];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (word == pattern_word(c)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (write_mask_in[b]) begin
                            pattern_d[c][8*b +: 8] = write_value_in[8*b +: 8];
                        end
                    end
                end
                if (word == cfg_word(c)) begin
                    if (write_mask_in[0]) begin
                        len_d[c] = write_value_in[CFG_LEN_LSB +: CFG_LEN_W];
                    end
`ifdef BUS_SNIFFER_RESET_EN
                    if (write_mask_in[1]) begin
                        mode_d[c] = write_value_in[CFG_MODE_BIT];
                    end
`endif
                end
            end
        end
        status_d = status_d | match_d;
        irq_d    = |(status_d & ctrl_d & ~mode_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q    <= '0;
            count_q   <= '0;
            ctrl_q    <= '0;
            status_q  <= '0;
            mode_q    <= '0;
            match_out <= '0;
            irq_out   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                pattern_q[c] <= '0;
                len_q[c]     <= '0;
            end
        end else begin
            if (snoop_valid_in) begin
                hist_q  <= window;
                count_q <= avail;
            end
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            mode_q    <= mode_d;
            match_out <= match_d;
            irq_out   <= irq_d;
            for (int c = 0; c < CHANNELS; c++) begin
                pattern_q[c] <= pattern_d[c];
                len_q[c]     <= len_d[c];
            end
        end
    end

    // Register read mux.
    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            if (word == WORD_CTRL) begin
                read_value_out[CHANNELS-1:0] = ctrl_q;
            end else if (word == WORD_STATUS) begin
                read_value_out[CHANNELS-1:0] = status_q;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (word == pattern_word(c)) begin
                    read_value_out = pattern_q[c];
                end
                if (word == cfg_word(c)) begin
                    read_value_out[CFG_LEN_LSB +: CFG_LEN_W] = len_q[c];
                    read_value_out[CFG_MODE_BIT]             = mode_q[c];
                end
            end
        end
    end

`ifdef BUS_SNIFFER_RESET_EN
    localparam int PULSE_CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    rst_state_e          state_q;
    logic [PULSE_CW-1:0] pulse_cnt_q;

    // IDLE -> PULSE on any MODE=1 hit. The counter loads PULSE_CYCLES-1 and
    // PULSE exits after it reaches zero, giving exactly PULSE_CYCLES clocks.
    // Hits while in PULSE are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_IDLE;
            pulse_cnt_q <= '0;
        end else if (state_q == RST_IDLE) begin
            if (|(match_d & mode_q)) begin
                state_q     <= RST_PULSE;
                pulse_cnt_q <= PULSE_CW'(PULSE_CYCLES - 1);
            end
        end else begin
            if (pulse_cnt_q == '0) begin
                state_q <= RST_IDLE;
            end else begin
                pulse_cnt_q <= pulse_cnt_q - 1'b1;
            end
        end
    end

    assign reset_req_out = (state_q == RST_PULSE);
`else
    logic unused_pulse;

    assign unused_pulse  = (PULSE_CYCLES > 0);
    assign reset_req_out = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sniffer.sv
module tb_bus_sniffer;

    localparam int CH = 2;
    localparam int ML = 4;
    localparam int PC = 16;
    localparam int EW = CH + 2;

`ifdef BUS_SNIFFER_RESET_EN
    localparam bit HAS_RST = 1'b1;
`else
    localparam bit HAS_RST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          snoop_valid_in;
    logic [7:0]    snoop_data_in;
    logic [31:0]   address_in;
    logic          sel_in;
    logic          read_in;
    logic [31:0]   read_value_out;
    logic [3:0]    write_mask_in;
    logic [31:0]   write_value_in;
    logic          ready_out;
    logic [CH-1:0] match_out;
    logic          irq_out;
    logic          reset_req_out;

    bus_sniffer #(
        .CHANNELS     (CH),
        .MAX_LEN      (ML),
        .PULSE_CYCLES (PC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .snoop_valid_in (snoop_valid_in),
        .snoop_data_in  (snoop_data_in),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out),
        .match_out      (match_out),
        .irq_out        (irq_out),
        .reset_req_out  (reset_req_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];   // {match[CH-1:0], irq, reset_req} per clock
    int            checks;
    int            errors;

    // Reference model: stream-level view of the register file.
    logic [7:0]    m_hist[$];  // last ML sniffed bytes, oldest first
    logic [CH-1:0] m_en;
    logic [CH-1:0] m_st;
    logic [CH-1:0] m_mode;
    logic [31:0]   m_pat [CH];
    logic [2:0]    m_len [CH];
    int            m_pulse;    // clocks of reset request still to come

    logic [7:0]    alpha [6] = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h6C, 8'h74};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_hist.delete();
        m_en = '0; m_st = '0; m_mode = '0; m_pulse = 0;
        for (int c = 0; c < CH; c++) begin
            m_pat[c] = '0;
            m_len[c] = '0;
        end
    endfunction

    function automatic logic [CH-1:0] model_match();
        logic [CH-1:0] r;
        int n;
        bit ok;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            n = (int'(m_len[c]) > ML) ? ML : int'(m_len[c]);
            if (m_en[c] && n > 0 && m_hist.size() >= n) begin
                ok = 1'b1;
                for (int i = 0; i < n; i++) begin
                    if (m_hist[m_hist.size() - n + i] != m_pat[c][8*i +: 8]) ok = 1'b0;
                end
                r[c] = ok;
            end
        end
        return r;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] mask, input logic [31:0] d);
        int w;
        w = int'(a[7:2]);
        if (w == 0 && mask[0]) m_en = d[CH-1:0];
        if (w == 1 && mask[0]) m_st = m_st & ~d[CH-1:0];
        for (int c = 0; c < CH; c++) begin
            if (w == 2 + 2*c) begin
                for (int b = 0; b < 4; b++) if (mask[b]) m_pat[c][8*b +: 8] = d[8*b +: 8];
            end
            if (w == 3 + 2*c) begin
                if (mask[0]) m_len[c] = d[2:0];
                if (mask[1] && HAS_RST) m_mode[c] = d[8];
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int w;
        r = '0;
        w = int'(a[7:2]);
        if (w == 0) r[CH-1:0] = m_en;
        if (w == 1) r[CH-1:0] = m_st;
        for (int c = 0; c < CH; c++) begin
            if (w == 2 + 2*c) r = m_pat[c];
            if (w == 3 + 2*c) begin
                r[2:0] = m_len[c];
                r[8]   = m_mode[c];
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; occupies exactly one rising edge.
    task automatic drive_cycle(input bit sv, input logic [7:0] b, input bit wr,
                               input logic [31:0] a, input logic [3:0] mask, input logic [31:0] d);
        logic [CH-1:0] mt;
        bit            trig;
        snoop_valid_in = sv;
        snoop_data_in  = b;
        sel_in         = wr;
        read_in        = 1'b0;
        address_in     = a;
        write_mask_in  = wr ? mask : 4'h0;
        write_value_in = d;
        mt = '0;
        if (sv) begin
            m_hist.push_back(b);
            if (m_hist.size() > ML) void'(m_hist.pop_front());
            mt = model_match();
        end
        trig = |(mt & m_mode);
        if (wr) model_write(a, mask, d);
        m_st = m_st | mt;
        if (m_pulse > 0) m_pulse--;
        else if (trig) m_pulse = PC;
        exp_q.push_back({mt, |(m_st & m_en & ~m_mode), (m_pulse > 0)});
        @(posedge clk);
        @(negedge clk);
        snoop_valid_in = 1'b0;
        sel_in         = 1'b0;
        write_mask_in  = 4'h0;
    endtask

    task automatic snoop(input logic [7:0] b);
        drive_cycle(1'b1, b, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive_cycle(1'b0, 8'h00, 1'b1, a, 4'hF, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Combinational read within the low clock phase.
    task automatic read_check(input string name, input logic [31:0] a);
        sel_in     = 1'b1;
        read_in    = 1'b1;
        address_in = a;
        #1;
        check(name, read_value_out, model_read(a));
        check("ready_sel", {31'b0, ready_out}, 32'h1);
        sel_in  = 1'b0;
        read_in = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #1;
                check("match_out", 32'(match_out), 32'(e[EW-1:2]));
                check("irq_out", {31'b0, irq_out}, {31'b0, e[1]});
                check("reset_req_out", {31'b0, reset_req_out}, {31'b0, e[0]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int kind;
        logic [5:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  mask;
        checks = 0;
        errors = 0;
        snoop_valid_in = 0; snoop_data_in = 0; address_in = 0; sel_in = 0;
        read_in = 0; write_mask_in = 0; write_value_in = 0;
        do_reset();

        // Reset state.
        check("rst_match", 32'(match_out), 32'h0);
        check("rst_irq", {31'b0, irq_out}, 32'h0);
        check("rst_req", {31'b0, reset_req_out}, 32'h0);
        read_check("rst_ctrl", 32'h00);
        read_check("rst_status", 32'h04);
        read_check("rst_pat0", 32'h08);
        read_check("rst_cfg1", 32'h14);

        // Unselected bus reads 0 and is not ready.
        wr(32'h08, 32'hDEAD_BEEF);
        address_in = 32'h08;
        #1;
        check("nosel_data", read_value_out, 32'h0);
        check("nosel_ready", {31'b0, ready_out}, 32'h0);
        read_check("pat0_rb", 32'h08);
        drive_cycle(1'b0, 8'h00, 1'b1, 32'h08, 4'b0010, 32'h0000_5500);
        read_check("pat0_lane1", 32'h08);

        // ch0 "lta", LEN=3, MODE=1: overlapping 6C 6C 74 61, then a second hit in PULSE.
        wr(32'h08, 32'h0061_746C);
        wr(32'h0C, 32'h0000_0103);
        wr(32'h00, 32'h1);
        read_check("cfg0_mode", 32'h0C);
        snoop(8'h6C); snoop(8'h6C); snoop(8'h74); snoop(8'h61);
        idle(2);
        snoop(8'h6C); snoop(8'h74); snoop(8'h61);
        idle(14);
        read_check("status_ch0", 32'h04);

        // Retrigger and reset asynchronously in pulse clock 5.
        snoop(8'h6C); snoop(8'h74); snoop(8'h61);
        idle(4);
        reset_n = 1'b0;
        #1;
        check("async_req", {31'b0, reset_req_out}, 32'h0);
        check("async_match", 32'(match_out), 32'h0);
        exp_q.delete();
        model_clear();
        read_check("async_cfg0", 32'h0C);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // ch1 "AB", LEN=2, MODE=0: STATUS and irq, then W1C.
        wr(32'h10, 32'h0000_4241);
        wr(32'h14, 32'h0000_0002);
        wr(32'h00, 32'h2);
        snoop(8'h41); snoop(8'h42);
        read_check("status_ab", 32'h04);
        idle(1);
        wr(32'h04, 32'h2);
        idle(1);
        read_check("status_clr", 32'h04);

        // W1C coinciding with a new ch1 match: set wins.
        snoop(8'h41);
        drive_cycle(1'b1, 8'h42, 1'b1, 32'h04, 4'h1, 32'h2);
        read_check("status_set_wins", 32'h04);
        idle(1);

        // LEN=0 never matches; LEN=7 acts as LEN=4.
        wr(32'h08, 32'h4443_4241);
        wr(32'h0C, 32'h0000_0000);
        wr(32'h00, 32'h3);
        snoop(8'h41); snoop(8'h42); snoop(8'h43); snoop(8'h44);
        wr(32'h0C, 32'h0000_0007);
        snoop(8'h43); snoop(8'h44);
        snoop(8'h41); snoop(8'h42); snoop(8'h43); snoop(8'h44);
        read_check("cfg0_len7", 32'h0C);
        wr(32'h04, 32'h3);
        idle(20);

        // Randomized traffic with register accesses.
        for (int it = 0; it < 500; it++) begin
            kind = $urandom_range(0, 9);
            w    = 6'($urandom_range(0, 7));
            a    = ($urandom() & 32'hFFFF_FF03) | {24'b0, w, 2'b00};
            mask = 4'($urandom_range(0, 15));
            d    = $urandom();
            if (w == 2 || w == 4)
                d = {alpha[$urandom_range(0, 5)], alpha[$urandom_range(0, 5)],
                     alpha[$urandom_range(0, 5)], alpha[$urandom_range(0, 5)]};
            if (w == 3 || w == 5)
                d = d & (($urandom_range(0, 3) == 0) ? 32'h0000_0107 : 32'h0000_0007);
            if (kind < 6)
                snoop(alpha[$urandom_range(0, 5)]);
            else if (kind < 8)
                drive_cycle(1'b1, alpha[$urandom_range(0, 5)], 1'b1, a, mask, d);
            else if (kind == 8)
                drive_cycle(1'b0, 8'h00, 1'b1, a, mask, d);
            else begin
                read_check("rand_read", a);
                idle(1);
            end
        end
        idle(PC + 2);
        read_check("final_status", 32'h04);
        read_check("final_cfg0", 32'h0C);

        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
